// File: rtl/sdram_fifo_ctrl.sv
// SDRAM-side agent for the user write/read FIFOs: issues burst requests from fill levels,
// owns the wrapping burst address pointers and FIFO-clear pulses. SDRAM_FIFO_RR_EN selects round-robin arbitration.
module sdram_fifo_ctrl #(
    parameter int ADDR_W    = 24,
    parameter int NUM_W     = 10,
    parameter int BURST_LEN = 256,
    parameter int WR_BASE   = 0,
    parameter int WR_END    = 1024,
    parameter int RD_BASE   = 0,
    parameter int RD_END    = 1024,
    parameter int RD_THRESH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              rd_en,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic [NUM_W-1:0]  wr_fifo_num,
    input  logic [NUM_W-1:0]  rd_fifo_num,
    output logic              sdram_wr_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    input  logic              sdram_wr_ack,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    input  logic              sdram_rd_ack,
    output logic [NUM_W-1:0]  burst_len,
    output logic              wr_fifo_rst,
    output logic              rd_fifo_rst
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST} state_t;

    localparam logic [NUM_W-1:0]  BURST_N   = NUM_W'(BURST_LEN);
    localparam logic [ADDR_W:0]   BURST_A   = (ADDR_W+1)'(BURST_LEN);
    localparam logic [ADDR_W-1:0] WR_BASE_A = ADDR_W'(WR_BASE);
    localparam logic [ADDR_W-1:0] RD_BASE_A = ADDR_W'(RD_BASE);
    localparam logic [ADDR_W:0]   WR_END_A  = (ADDR_W+1)'(WR_END);
    localparam logic [ADDR_W:0]   RD_END_A  = (ADDR_W+1)'(RD_END);

    state_t            state, state_nxt;
    logic [NUM_W-1:0]  beat_cnt;
    logic              wr_load_pend, rd_load_pend;
    logic              wr_req_nxt, rd_req_nxt;
    logic              wr_busy, rd_busy, wr_beat, rd_beat, beat_last, wr_done, rd_done;
    logic              wr_do_load, rd_do_load, idle_ok, wr_elig, rd_elig, pick_wr, pick_rd;
    logic [ADDR_W:0]   wr_sum, rd_sum;
    logic [ADDR_W-1:0] wr_addr_next, rd_addr_next;

    assign burst_len = BURST_N;

    assign wr_busy   = (state == WR_REQ) || (state == WR_BURST);
    assign rd_busy   = (state == RD_REQ) || (state == RD_BURST);
    assign wr_beat   = wr_busy && sdram_wr_ack;
    assign rd_beat   = rd_busy && sdram_rd_ack;
    assign beat_last = (beat_cnt + NUM_W'(1)) == BURST_N;
    assign wr_done   = wr_beat && beat_last;
    assign rd_done   = rd_beat && beat_last;

    // A load that lands during its own burst is deferred until the FSM is back in IDLE.
    assign wr_do_load = (wr_load && !wr_busy) || (wr_load_pend && state == IDLE);
    assign rd_do_load = (rd_load && !rd_busy) || (rd_load_pend && state == IDLE);

    // Hold off new bursts while a clear is pending or in flight, so fill levels are fresh.
    assign idle_ok = init_done && !wr_load && !rd_load && !wr_load_pend && !rd_load_pend
                     && !wr_fifo_rst && !rd_fifo_rst;
    assign wr_elig = 32'(wr_fifo_num) >= BURST_LEN;
    assign rd_elig = rd_en && (32'(rd_fifo_num) < RD_THRESH);

`ifdef SDRAM_FIFO_RR_EN
    logic last_wr;
    assign pick_wr = wr_elig && (!rd_elig || !last_wr);
`else
    assign pick_wr = wr_elig;
`endif
    assign pick_rd = rd_elig && !pick_wr;

    // Wrap compare is done one bit wider so the sum cannot overflow before comparing.
    assign wr_sum       = {1'b0, sdram_wr_addr} + BURST_A;
    assign rd_sum       = {1'b0, sdram_rd_addr} + BURST_A;
    assign wr_addr_next = (wr_sum >= WR_END_A) ? WR_BASE_A : wr_sum[ADDR_W-1:0];
    assign rd_addr_next = (rd_sum >= RD_END_A) ? RD_BASE_A : rd_sum[ADDR_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (idle_ok && pick_wr)      state_nxt = WR_REQ;
                else if (idle_ok && pick_rd) state_nxt = RD_REQ;
            end
            WR_REQ, WR_BURST: begin
                if (wr_done)      state_nxt = IDLE;
                else if (wr_beat) state_nxt = WR_BURST;
            end
            RD_REQ, RD_BURST: begin
                if (rd_done)      state_nxt = IDLE;
                else if (rd_beat) state_nxt = RD_BURST;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_req_nxt = (state_nxt == WR_REQ);
        rd_req_nxt = (state_nxt == RD_REQ);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sdram_wr_req  <= 1'b0;
            sdram_rd_req  <= 1'b0;
            sdram_wr_addr <= WR_BASE_A;
            sdram_rd_addr <= RD_BASE_A;
            wr_fifo_rst   <= 1'b0;
            rd_fifo_rst   <= 1'b0;
            beat_cnt      <= '0;
            wr_load_pend  <= 1'b0;
            rd_load_pend  <= 1'b0;
        end else begin
            sdram_wr_req <= wr_req_nxt;
            sdram_rd_req <= rd_req_nxt;
            wr_fifo_rst  <= wr_do_load;
            rd_fifo_rst  <= rd_do_load;

            if (wr_done || rd_done)      beat_cnt <= '0;
            else if (wr_beat || rd_beat) beat_cnt <= beat_cnt + NUM_W'(1);

            if (wr_load && wr_busy) wr_load_pend <= 1'b1;
            else if (wr_do_load)    wr_load_pend <= 1'b0;
            if (rd_load && rd_busy) rd_load_pend <= 1'b1;
            else if (rd_do_load)    rd_load_pend <= 1'b0;

            if (wr_do_load)   sdram_wr_addr <= WR_BASE_A;
            else if (wr_done) sdram_wr_addr <= wr_addr_next;
            if (rd_do_load)   sdram_rd_addr <= RD_BASE_A;
            else if (rd_done) sdram_rd_addr <= rd_addr_next;
        end
    end

`ifdef SDRAM_FIFO_RR_EN
    // Resets to "read served last" so write wins the first contested decision.
    always_ff @(posedge clk) begin
        if (!rst_n)                                  last_wr <= 1'b0;
        else if (state == IDLE && state_nxt == WR_REQ) last_wr <= 1'b1;
        else if (state == IDLE && state_nxt == RD_REQ) last_wr <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Directed self-checking bench for sdram_fifo_ctrl with BURST_LEN=4, WR_END=RD_END=8.
module tb_sdram_fifo_ctrl;

    localparam int ADDR_W = 24;
    localparam int NUM_W  = 10;

    logic              clk, rst_n, init_done, rd_en, wr_load, rd_load;
    logic [NUM_W-1:0]  wr_fifo_num, rd_fifo_num;
    logic              sdram_wr_req, sdram_rd_req, sdram_wr_ack, sdram_rd_ack;
    logic [ADDR_W-1:0] sdram_wr_addr, sdram_rd_addr;
    logic [NUM_W-1:0]  burst_len;
    logic              wr_fifo_rst, rd_fifo_rst;

    int checks = 0;
    int errors = 0;
    int n;
    int dir;
    int exp_seq [4];
    logic [5:0] gap_pat;

    sdram_fifo_ctrl #(
        .ADDR_W(ADDR_W), .NUM_W(NUM_W), .BURST_LEN(4),
        .WR_BASE(0), .WR_END(8), .RD_BASE(0), .RD_END(8), .RD_THRESH(256)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .rd_en(rd_en),
        .wr_load(wr_load), .rd_load(rd_load),
        .wr_fifo_num(wr_fifo_num), .rd_fifo_num(rd_fifo_num),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr), .sdram_wr_ack(sdram_wr_ack),
        .sdram_rd_req(sdram_rd_req), .sdram_rd_addr(sdram_rd_addr), .sdram_rd_ack(sdram_rd_ack),
        .burst_len(burst_len), .wr_fifo_rst(wr_fifo_rst), .rd_fifo_rst(rd_fifo_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_acks(input int cnt);
        repeat (cnt) begin
            sdram_wr_ack = 1'b1;
            tick();
        end
        sdram_wr_ack = 1'b0;
    endtask

    task automatic rd_acks(input int cnt);
        repeat (cnt) begin
            sdram_rd_ack = 1'b1;
            tick();
        end
        sdram_rd_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
`ifdef SDRAM_FIFO_RR_EN
        exp_seq = '{1, 2, 1, 2};
`else
        exp_seq = '{1, 1, 1, 1};
`endif
        rst_n = 1'b0; init_done = 1'b0; rd_en = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
        wr_fifo_num = '0; rd_fifo_num = '0; sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        tick(); tick();
        check("rst_wr_req", sdram_wr_req, 0);
        check("rst_rd_req", sdram_rd_req, 0);
        check("rst_wr_addr", sdram_wr_addr, 0);
        check("rst_rd_addr", sdram_rd_addr, 0);
        check("rst_wr_fifo_rst", wr_fifo_rst, 0);
        check("rst_rd_fifo_rst", rd_fifo_rst, 0);
        check("burst_len", burst_len, 4);

        // Priority and wrap: both eligible, write goes first.
        rst_n = 1'b1; init_done = 1'b1; wr_fifo_num = 10'd4; rd_en = 1'b1; rd_fifo_num = '0;
        tick();
        check("prio_wr_req", sdram_wr_req, 1);
        check("prio_rd_req", sdram_rd_req, 0);
        check("prio_wr_addr", sdram_wr_addr, 0);
        wr_acks(1);
        check("wr_req_drop", sdram_wr_req, 0);
        wr_acks(2);
        check("wr_addr_midburst", sdram_wr_addr, 0);
        wr_acks(1);
        check("wr_addr_after1", sdram_wr_addr, 4);
        wr_fifo_num = '0;
        tick();
        check("rd_req_second", sdram_rd_req, 1);
        check("rd_addr_first", sdram_rd_addr, 0);
        check("wr_req_idle", sdram_wr_req, 0);
        rd_acks(4);
        check("rd_addr_after1", sdram_rd_addr, 4);
        rd_en = 1'b0; wr_fifo_num = 10'd4;
        tick();
        check("wr2_req", sdram_wr_req, 1);
        check("wr2_addr", sdram_wr_addr, 4);
        wr_acks(4);
        check("wr_addr_wrap", sdram_wr_addr, 0);
        tick();
        check("wr3_req", sdram_wr_req, 1);
        check("wr3_addr", sdram_wr_addr, 0);
        wr_acks(4);
        wr_fifo_num = '0;
        check("wr_addr_after3", sdram_wr_addr, 4);

        // Handshake: req held 5 cycles until the first ack, then gapped acks.
        wr_fifo_num = 10'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hs_req_hold_%0d", i), sdram_wr_req, 1);
        end
        gap_pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            sdram_wr_ack = gap_pat[i];
            tick();
            if (i == 0) begin
                check("hs_req_drop", sdram_wr_req, 0);
                wr_fifo_num = '0;
            end
            if (i == 4) check("hs_not_done_3acks", sdram_wr_addr, 4);
        end
        sdram_wr_ack = 1'b0;
        check("hs_done_wrap", sdram_wr_addr, 0);
        check("hs_req_low", sdram_wr_req, 0);

        // Load during own burst is deferred until after the burst.
        wr_fifo_num = 10'd4;
        tick();
        check("ld_wr_req", sdram_wr_req, 1);
        wr_acks(2);
        wr_load = 1'b1;
        tick();
        wr_load = 1'b0;
        check("ld_deferred_rst", wr_fifo_rst, 0);
        wr_acks(2);
        check("ld_burst_done_addr", sdram_wr_addr, 4);
        check("ld_burst_done_rst", wr_fifo_rst, 0);
        tick();
        check("ld_fifo_rst_pulse", wr_fifo_rst, 1);
        check("ld_addr_base", sdram_wr_addr, 0);
        check("ld_no_req", sdram_wr_req, 0);
        tick();
        check("ld_fifo_rst_end", wr_fifo_rst, 0);
        check("ld_no_req2", sdram_wr_req, 0);
        tick();
        check("ld_req_resume", sdram_wr_req, 1);
        wr_acks(4);
        wr_fifo_num = '0;
        check("ld_addr_after", sdram_wr_addr, 4);

        // Simultaneous loads in IDLE.
        wr_load = 1'b1; rd_load = 1'b1;
        tick();
        wr_load = 1'b0; rd_load = 1'b0;
        check("both_wr_rst", wr_fifo_rst, 1);
        check("both_rd_rst", rd_fifo_rst, 1);
        check("both_wr_addr", sdram_wr_addr, 0);
        check("both_rd_addr", sdram_rd_addr, 0);
        tick();
        check("both_wr_rst_end", wr_fifo_rst, 0);
        check("both_rd_rst_end", rd_fifo_rst, 0);

        // Mid-burst reset during a read.
        rd_en = 1'b1;
        tick();
        check("rr_rd_req", sdram_rd_req, 1);
        rd_acks(4);
        check("rr_rd_addr", sdram_rd_addr, 4);
        tick();
        check("rr_rd_req2", sdram_rd_req, 1);
        rd_acks(2);
        rst_n = 1'b0;
        tick();
        check("mrst_rd_req", sdram_rd_req, 0);
        check("mrst_wr_req", sdram_wr_req, 0);
        check("mrst_rd_addr", sdram_rd_addr, 0);
        check("mrst_wr_addr", sdram_wr_addr, 0);
        check("mrst_rd_rst", rd_fifo_rst, 0);
        rst_n = 1'b1; rd_en = 1'b0;
        rd_acks(2);
        check("stray_ack_addr", sdram_rd_addr, 0);
        check("stray_ack_req", sdram_rd_req, 0);

        // Read gating: each case must never raise a request.
        for (int c = 0; c < 3; c++) begin
            init_done   = (c != 0);
            rd_en       = (c != 1);
            rd_fifo_num = (c == 2) ? 10'd256 : 10'd0;
            repeat (4) tick();
            check($sformatf("gate_rd_req_%0d", c), sdram_rd_req, 0);
            check($sformatf("gate_wr_req_%0d", c), sdram_wr_req, 0);
        end

        // Arbitration sequence with both sides continuously eligible.
        init_done = 1'b1; rd_en = 1'b1; rd_fifo_num = '0; wr_fifo_num = 10'd4;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(sdram_wr_req || sdram_rd_req) && n < 10) begin
                tick();
                n++;
            end
            dir = sdram_wr_req ? 1 : (sdram_rd_req ? 2 : 0);
            check($sformatf("arb_%0d", k), dir, exp_seq[k]);
            if (dir == 1)      wr_acks(4);
            else if (dir == 2) rd_acks(4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
